// File: rtl/ipref_stream_buffer_if.sv
// Lookup and line-fetch bundle of the instruction prefetch stream buffer.
// master: the stream buffer itself; slave: the I$ miss path plus the memory adapter.
interface ipref_stream_buffer_if #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned LINE_WIDTH = 128
);
  logic                  pf_req;
  logic [PLEN-1:0]       pf_addr;
  logic                  pf_resp_valid;
  logic                  found_block;
  logic                  ready_block;
  logic [LINE_WIDTH-1:0] pf_data;
  logic                  mem_req;
  logic [PLEN-1:0]       mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [LINE_WIDTH-1:0] mem_rdata;

  modport master (
    input  pf_req, pf_addr, mem_gnt, mem_rvalid, mem_rdata,
    output pf_resp_valid, found_block, ready_block, pf_data, mem_req, mem_addr
  );

  modport slave (
    output pf_req, pf_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  pf_resp_valid, found_block, ready_block, pf_data, mem_req, mem_addr
  );
endinterface

// File: rtl/ipref_stream_buffer.sv
// Sequential-line instruction prefetch stream buffer: a FIFO of prefetched lines whose
// head is checked on each I$ miss; a mismatch restarts the stream after the miss line.
module ipref_stream_buffer #(
  parameter int unsigned SB_DEPTH       = 4,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned LOG2_PAGE_SIZE = 12,
  parameter int unsigned PLEN           = 56
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 flush_i,
  ipref_stream_buffer_if.master bus,
  output logic                 SB_full_o,
  output logic                 SB_empty_o,
  output logic                 ipref_hit_o,
  output logic                 ipref_miss_o
);
  localparam int unsigned LINE_OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int unsigned TAG_W       = PLEN - LINE_OFFSET;
  localparam int unsigned PAGE_SHIFT  = LOG2_PAGE_SIZE - LINE_OFFSET;
  localparam int unsigned PAGE_W      = TAG_W - PAGE_SHIFT;
  localparam int unsigned PTR_W       = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fsm_e;

  function automatic logic [PAGE_W-1:0] page_of(input logic [TAG_W-1:0] line);
    return line[TAG_W-1:PAGE_SHIFT];
  endfunction

  logic [SB_DEPTH-1:0]   valid_r;
  logic [SB_DEPTH-1:0]   rdy_r;
  logic [TAG_W-1:0]      tag_r  [SB_DEPTH];
  logic [LINE_WIDTH-1:0] data_r [SB_DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [PTR_W-1:0]      fetch_idx_r;
  logic [CNT_W-1:0]      count_r;
  logic                  stream_r;
  logic [TAG_W-1:0]      next_line_r;
  logic [PAGE_W-1:0]     base_page_r;

  fsm_e                  state_r;
  logic                  mem_req_r;
  logic [PLEN-1:0]       mem_addr_r;
  logic                  drain_pend_r;

  logic                  resp_valid_r;
  logic                  found_r;
  logic                  ready_blk_r;
  logic [LINE_WIDTH-1:0] pf_data_r;
  logic                  hit_r;
  logic                  miss_r;
  logic                  full_r;
  logic                  empty_r;

  logic [TAG_W-1:0]      req_line_s;
  logic                  head_match_s;
  logic                  lookup_s;
  logic                  hit_s;
  logic                  pend_s;
  logic                  restart_s;
  logic                  kill_s;
  logic                  alloc_s;
  logic                  fill_s;
  logic                  in_page_s;
  logic                  start_s;
  logic [CNT_W-1:0]      count_nxt_s;

  // A flush masks the lookup, so a flushed request can neither hit nor restart.
  assign req_line_s   = bus.pf_addr[PLEN-1:LINE_OFFSET];
  assign head_match_s = valid_r[head_r] & (tag_r[head_r] == req_line_s);
  assign lookup_s     = bus.pf_req & ~flush_i & en_i;
  assign hit_s        = lookup_s & head_match_s & rdy_r[head_r];
  assign pend_s       = lookup_s & head_match_s & ~rdy_r[head_r];
  assign restart_s    = lookup_s & ~head_match_s;
  assign kill_s       = flush_i | restart_s;
  assign alloc_s      = (state_r == REQ) & bus.mem_gnt & ~kill_s & ~drain_pend_r;
  assign fill_s       = (state_r == WAIT) & bus.mem_rvalid & ~kill_s;
  assign in_page_s    = (page_of(next_line_r) == base_page_r);
  assign start_s      = (state_r == IDLE) & en_i & stream_r & in_page_s & ~kill_s
                        & (count_r != CNT_W'(SB_DEPTH));

  // Occupancy after this edge; a pop and an allocation together cancel out.
  always_comb begin
    count_nxt_s = count_r;
    if (kill_s) begin
      count_nxt_s = '0;
    end else if (alloc_s && !hit_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (hit_s && !alloc_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Entry storage, FIFO pointers and stream position.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r     <= '0;
      rdy_r       <= '0;
      head_r      <= '0;
      tail_r      <= '0;
      fetch_idx_r <= '0;
      count_r     <= '0;
      stream_r    <= 1'b0;
      next_line_r <= '0;
      base_page_r <= '0;
    end else begin
      count_r <= count_nxt_s;
      if (kill_s) begin
        valid_r <= '0;
        rdy_r   <= '0;
        head_r  <= '0;
        tail_r  <= '0;
        if (flush_i) begin
          stream_r <= 1'b0;
        end else begin
          stream_r    <= 1'b1;
          next_line_r <= req_line_s + TAG_W'(1);
          base_page_r <= page_of(req_line_s);
        end
      end else begin
        if (alloc_s) begin
          valid_r[tail_r] <= 1'b1;
          rdy_r[tail_r]   <= 1'b0;
          tag_r[tail_r]   <= next_line_r;
          fetch_idx_r     <= tail_r;
          tail_r          <= tail_r + PTR_W'(1);
          next_line_r     <= next_line_r + TAG_W'(1);
        end
        if (fill_s) begin
          rdy_r[fetch_idx_r]  <= 1'b1;
          data_r[fetch_idx_r] <= bus.mem_rdata;
        end
        if (hit_s) begin
          valid_r[head_r] <= 1'b0;
          rdy_r[head_r]   <= 1'b0;
          head_r          <= head_r + PTR_W'(1);
        end
      end
    end
  end

  // Single-outstanding line fetch; a killed fetch is still granted/answered, then dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
      drain_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r      <= REQ;
            mem_req_r    <= 1'b1;
            mem_addr_r   <= {next_line_r, {LINE_OFFSET{1'b0}}};
            drain_pend_r <= 1'b0;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            mem_req_r    <= 1'b0;
            drain_pend_r <= 1'b0;
            state_r      <= (kill_s || drain_pend_r) ? DRAIN : WAIT;
          end else if (kill_s) begin
            drain_pend_r <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state_r <= IDLE;
          end else if (kill_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          mem_req_r    <= 1'b0;
          drain_pend_r <= 1'b0;
        end
      endcase
    end
  end

  // Lookup response and occupancy flags, all registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_r <= 1'b0;
      found_r      <= 1'b0;
      ready_blk_r  <= 1'b0;
      pf_data_r    <= '0;
      hit_r        <= 1'b0;
      miss_r       <= 1'b0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
    end else begin
      resp_valid_r <= bus.pf_req;
      found_r      <= hit_s | pend_s;
      ready_blk_r  <= hit_s;
      hit_r        <= hit_s;
      miss_r       <= bus.pf_req & ~hit_s & ~pend_s;
      pf_data_r    <= hit_s ? data_r[head_r] : '0;
      full_r       <= (count_nxt_s == CNT_W'(SB_DEPTH));
      empty_r      <= (count_nxt_s == '0);
    end
  end

  assign bus.pf_resp_valid = resp_valid_r;
  assign bus.found_block   = found_r;
  assign bus.ready_block   = ready_blk_r;
  assign bus.pf_data       = pf_data_r;
  assign bus.mem_req       = mem_req_r;
  assign bus.mem_addr      = mem_addr_r;
  assign SB_full_o         = full_r;
  assign SB_empty_o        = empty_r;
  assign ipref_hit_o       = hit_r;
  assign ipref_miss_o      = miss_r;
endmodule

// File: doc/ipref_stream_buffer.md
IPREF_STREAM_BUFFER -- requirements
Module: ipref_stream_buffer

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, number of line entries (power of 2, >=2).
REQ-002 SHALL have parameter LINE_WIDTH, default 128, line size in bits; LINE_OFFSET = log2(LINE_WIDTH/8).
REQ-003 SHALL have parameter LOG2_PAGE_SIZE, default 12, page size for the prefetch stop boundary.
REQ-004 SHALL have parameter PLEN, default riscv::PLEN, physical address width.
REQ-005 SHALL have port clk_i  in  1  clock; one clock domain, all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports en_i in 1 (prefetcher enable) and flush_i in 1 (invalidate all entries).
REQ-008 SHALL have ports pf_req_i in 1 and pf_addr_i in PLEN: I$ miss lookup request and miss address.
REQ-009 SHALL have ports pf_resp_valid_o out 1, found_block_o out 1, ready_block_o out 1, pf_data_o out LINE_WIDTH: lookup result.
REQ-010 SHALL have ports mem_req_o out 1, mem_addr_o out PLEN, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in LINE_WIDTH: line-fetch port toward the AXI adapter.
REQ-011 SHALL have ports SB_full_o out 1, SB_empty_o out 1, ipref_hit_o out 1, ipref_miss_o out 1.

Function
REQ-012 SHALL hold per entry: valid, ready (data present), line tag (PLEN-LINE_OFFSET bits), data; circular FIFO with head, tail, and count (log2(SB_DEPTH)+1 bits).
REQ-013 SHALL compare only the head entry on lookup; result is registered, pf_resp_valid_o pulses exactly 1 cycle after pf_req_i.
REQ-014 SHALL report hit (found=1, ready=1, pf_data_o=head data, ipref_hit_o pulse) when head valid, ready, and tag matches; head pops in the same cycle the response is driven.
REQ-015 SHALL report pending (found=1, ready=0) when head valid, tag matches, data not yet returned; no pop, no state change; requester retries.
REQ-016 SHALL report miss (found=0, ready=0, ipref_miss_o pulse) otherwise; on miss, all entries invalidate and a new stream starts at next line = line(pf_addr_i)+1 within page(pf_addr_i).
REQ-017 SHALL, while en_i=0, answer every lookup as miss without restarting a stream and issue no new fetches.
REQ-018 SHALL allocate an entry (tag=next line, valid=1, ready=0) at mem_req_o handshake (mem_req_o & mem_gnt_i), then advance next line by 1.
REQ-019 SHALL stop allocating when count==SB_DEPTH or when next line crosses into a different page than the stream base.
REQ-020 SHALL keep at most one fetch outstanding; FSM states IDLE, REQ, WAIT, DRAIN.
REQ-021 SHALL transition IDLE->REQ when en_i, stream active, not full, within page; REQ->WAIT on mem_gnt_i; WAIT->IDLE on mem_rvalid_i, writing mem_rdata_i to the fetched entry and setting ready.
REQ-022 SHALL hold mem_req_o and mem_addr_o stable in REQ until mem_gnt_i; no retraction.
REQ-023 SHALL on miss-restart or flush_i during WAIT go to DRAIN, discard the next mem_rvalid_i, then IDLE; restart/flush during REQ completes the grant then goes to DRAIN.
REQ-024 SHALL keep count unchanged when a pop and an allocation occur in the same cycle.
REQ-025 SHALL drive SB_full_o = (count==SB_DEPTH) and SB_empty_o = (count==0), registered from state.
REQ-026 SHALL give flush_i priority over a simultaneous lookup; that lookup responds miss with no stream start.
REQ-027 SHALL wrap head and tail pointers modulo SB_DEPTH.

Reset
REQ-028 SHALL on rst_i clear all valid/ready bits, pointers, count, stream-active flag; FSM=IDLE.
REQ-029 SHALL drive all outputs 0 during and after reset except SB_empty_o=1.
REQ-030 SHALL drop any in-flight fetch at reset; the adapter is reset on the same rst_i.

Verification
REQ-031 SHALL cover: assert rst_i mid-WAIT -> next cycle mem_req_o=0, SB_empty_o=1, count=0, FSM=IDLE.
REQ-032 SHALL cover: miss 0x1000, gnt/rvalid 1 cycle -> ipref_miss_o pulse; fetches 0x1010,0x1020,0x1030,0x1040 in order; SB_full_o=1 after 4th grant.
REQ-033 SHALL cover: after fills, pf_req 0x1010 -> next cycle found=1, ready=1, data=fill data, ipref_hit_o=1; following fetch 0x1050.
REQ-034 SHALL cover: pf_req 0x1010 while its fill is in WAIT -> found=1, ready=0, count unchanged.
REQ-035 SHALL cover: miss 0x1FE0 -> only 0x1FF0 fetched; no request to 0x2000.
REQ-036 SHALL cover: miss 0x3000 during WAIT for 0x1020 -> 0x1020 data discarded, first new fetch 0x3010, no entry holds tag of 0x1020.
